imem_load_ctrl: RTL and testbench

Sequencing controller for the byte-organised instruction memory of the RV32I core. Accepts 32-bit program words over a valid/ready stream and writes them little-endian, one byte per cycle, through the memory's byte write port. Holds the fetch stage stalled until a complete program image has been loaded. Flags misaligned or out-of-range PCF values once fetch is released.

---
 rtl/imem_load_ctrl.sv | 105 ++++++++++
 tb/tb_imem_load_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: streams 32-bit program words into a byte-wide instruction memory and gates fetch until loaded
module imem_load_ctrl #(
  parameter int ElemWidth = 8,
  parameter int Depth     = 120,
  parameter int DPW       = 32,
  parameter int LenW      = $clog2(Depth/4+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [LenW-1:0]          load_len,
  input  logic                     wdata_valid,
  input  logic [DPW-1:0]           wdata,
  output logic                     wdata_ready,
  output logic                     mem_we,
  output logic [$clog2(Depth)-1:0] mem_waddr,
  output logic [ElemWidth-1:0]     mem_wdata,
  input  logic [DPW-1:0]           PCF,
  output logic                     fetch_stall,
  output logic                     load_done,
  output logic                     load_err,
  output logic                     fetch_fault,
  output logic                     busy
);
  localparam int MaxWords = Depth/4;
  localparam int AW = $clog2(Depth);
  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE_BYTE, DONE} state_t;
  state_t          state_q, state_d;
  logic [LenW-1:0] len_q, len_d, widx_q, widx_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [DPW-1:0]  word_q, word_d;
  logic            loaded_q, loaded_d, err_q, err_d, fault_q, fault_d;
  logic            len_ok;
  assign len_ok      = load_len != '0 && load_len <= LenW'(MaxWords);
  assign wdata_ready = state_q == WAIT_WORD;
  assign mem_we      = state_q == WRITE_BYTE;
  assign mem_waddr   = mem_we ? AW'({widx_q, bidx_q}) : '0;
  assign mem_wdata   = mem_we ? word_q[ElemWidth*bidx_q +: ElemWidth] : '0;
  assign load_done   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign fetch_stall = !(state_q == IDLE && loaded_q);
  assign load_err    = err_q;
  assign fetch_fault = fault_q && !fetch_stall;
  // state, counters and flags; the fault flag only tracks PCF once fetch is released
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      widx_q   <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      fault_q  <= fault_d;
    end
  end
  // next-state: accept a word, spill it out byte by byte, then mark the image loaded
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    fault_d  = !fetch_stall && (PCF[1:0] != 2'd0 || PCF > DPW'(Depth-4));
    case (state_q)
      IDLE: if (load_start) begin
        if (len_ok) begin
          len_d    = load_len;
          widx_d   = '0;
          err_d    = 1'b0;
          loaded_d = 1'b0;
          state_d  = WAIT_WORD;
        end else err_d = 1'b1;
      end
      WAIT_WORD: if (wdata_valid) begin
        word_d  = wdata;
        bidx_d  = 2'd0;
        state_d = WRITE_BYTE;
      end
      WRITE_BYTE: begin
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          state_d = widx_q == len_q - LenW'(1) ? DONE : WAIT_WORD;
          widx_d  = widx_q == len_q - LenW'(1) ? widx_q : widx_q + LenW'(1);
        end
      end
      DONE: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed and randomized checks of the instruction memory load controller
module tb_imem_load_ctrl;
  logic        clk = 1'b0, rst = 1'b1, load_start = 1'b0, wdata_valid = 1'b0;
  logic [5:0]  load_len = '0;
  logic [31:0] wdata = '0, PCF = '0;
  logic        wdata_ready, mem_we, fetch_stall, load_done, load_err, fetch_fault, busy;
  logic [6:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  int checks = 0, errors = 0, done_cnt = 0, d0;
  logic [31:0] prog [30];
  int wr_addr [$];
  int wr_data [$];

  imem_load_ctrl dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .PCF(PCF),
    .fetch_stall(fetch_stall), .load_done(load_done), .load_err(load_err),
    .fetch_fault(fetch_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_waddr));
      wr_data.push_back(int'(mem_wdata));
    end
    if (load_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n);
    chk({tag, "_nwr"}, wr_addr.size(), n);
    for (int k = 0; k < n && k < wr_addr.size(); k++) begin
      chk({tag, "_addr"}, wr_addr[k], k);
      chk({tag, "_byte"}, wr_data[k], (prog[k/4] >> (8*(k%4))) & 32'hFF);
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic fault_chk(input logic [31:0] v);
    @(negedge clk);
    PCF = v;
    @(negedge clk);
    chk("fetch_fault", fetch_fault, (v % 4 != 0) || (v > 32'd116));
  endtask

  task automatic run_load(input int n, input int p, input int abort_addr, input bit poke);
    int idx = 0, cyc = 0;
    bit got = 0, poked = 0;
    @(negedge clk);
    load_start = 1'b1;
    load_len = 6'(n);
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      load_start = 1'b0;
      if (cyc == 1) chk("fault_masked", fetch_fault, 0);
      if (load_done) begin
        got = 1;
        break;
      end
      if (abort_addr >= 0 && mem_we && int'(mem_waddr) == abort_addr) begin
        rst = 1'b1;
        wdata_valid = 1'b0;
        return;
      end
      if (poke && !poked && mem_we) begin
        load_start = 1'b1;
        load_len = 6'd1;
        poked = 1;
      end
      if (wdata_ready && idx < n && $urandom_range(0, 99) < p) begin
        wdata_valid = 1'b1;
        wdata = prog[idx];
        idx++;
      end else begin
        wdata_valid = wdata_ready ? 1'b0 : 1'($urandom_range(0, 1));
        wdata = $urandom;
      end
    end
    wdata_valid = 1'b0;
    chk("load_done_seen", got, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stall", fetch_stall, 1);
    chk("rst_ready", wdata_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_waddr, 0);
    chk("rst_data", mem_wdata, 0);
    rst = 1'b0;
    // rejected lengths
    foreach (prog[i]) prog[i] = $urandom;
    @(negedge clk);
    load_start = 1'b1;
    load_len = 6'd0;
    @(negedge clk);
    load_start = 1'b0;
    chk("len0_err", load_err, 1);
    chk("len0_busy", busy, 0);
    chk("len0_stall", fetch_stall, 1);
    load_start = 1'b1;
    load_len = 6'd31;
    @(negedge clk);
    load_start = 1'b0;
    chk("len31_err", load_err, 1);
    chk("len31_busy", busy, 0);
    chk("len31_stall", fetch_stall, 1);
    d0 = done_cnt;
    run_load(2, 60, -1, 0);
    repeat (2) @(negedge clk);
    chk("len2_err_clear", load_err, 0);
    chk("len2_done_once", done_cnt - d0, 1);
    check_log("len2", 8);
    // single word, cycle-exact
    prog[0] = 32'hFFC4A303;
    PCF = 32'h10;
    @(negedge clk);
    load_start = 1'b1;
    load_len = 6'd1;
    @(negedge clk);
    load_start = 1'b0;
    chk("w1_ready", wdata_ready, 1);
    chk("w1_busy", busy, 1);
    chk("w1_stall", fetch_stall, 1);
    chk("w1_we_wait", mem_we, 0);
    wdata_valid = 1'b1;
    wdata = prog[0];
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      wdata_valid = 1'b0;
      chk("w1_we", mem_we, 1);
      chk("w1_addr", mem_waddr, b);
      chk("w1_byte", mem_wdata, (prog[0] >> (8*b)) & 32'hFF);
      chk("w1_ready_low", wdata_ready, 0);
    end
    @(negedge clk);
    chk("w1_done", load_done, 1);
    chk("w1_done_stall", fetch_stall, 1);
    chk("w1_done_we", mem_we, 0);
    chk("w1_done_addr", mem_waddr, 0);
    chk("w1_done_data", mem_wdata, 0);
    @(negedge clk);
    chk("w1_done_off", load_done, 0);
    chk("w1_stall_off", fetch_stall, 0);
    chk("w1_busy_off", busy, 0);
    check_log("w1", 4);
    // five words, random valid
    prog[0] = 32'hFFC4A303;
    prog[1] = 32'h00402203;
    prog[2] = 32'h004283B3;
    prog[3] = 32'h000384B3;
    prog[4] = 32'h404383B3;
    d0 = done_cnt;
    run_load(5, 40, -1, 0);
    repeat (2) @(negedge clk);
    chk("w5_done_once", done_cnt - d0, 1);
    check_log("w5", 20);
    // fetch fault decode
    fault_chk(32'h10);
    fault_chk(32'h76);
    fault_chk(32'h78);
    fault_chk(32'h74);
    fault_chk(32'h80000010);
    fault_chk(32'hFFFFFFFC);
    for (int i = 0; i < 8; i++) fault_chk(i % 2 ? $urandom : 32'($urandom_range(0, 127)));
    // reset on the second byte of word 3
    foreach (prog[i]) prog[i] = $urandom;
    PCF = 32'h76;
    d0 = done_cnt;
    run_load(5, 70, 13, 0);
    @(negedge clk);
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stall", fetch_stall, 1);
    chk("abort_done", load_done, 0);
    rst = 1'b0;
    chk("abort_no_done", done_cnt - d0, 0);
    check_log("abort", 14);
    d0 = done_cnt;
    run_load(1, 100, -1, 0);
    repeat (2) @(negedge clk);
    chk("post_abort_done", done_cnt - d0, 1);
    chk("post_abort_stall", fetch_stall, 0);
    check_log("post_abort", 4);
    // load_start during writes is ignored
    foreach (prog[i]) prog[i] = $urandom;
    fault_chk(32'h76);
    d0 = done_cnt;
    run_load(3, 70, -1, 1);
    repeat (2) @(negedge clk);
    chk("poke_done_once", done_cnt - d0, 1);
    check_log("poke", 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
